// File: rtl/ascii_dec_rx_pkg.sv
// Shared ASCII constants, decoder state encoding and character helpers
// for the UART ASCII receive path.
package ascii_dec_rx_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam logic [2:0] NDIG_MAX = 3'd7;

    typedef enum logic [2:0] {
        S_READ  = 3'd0,
        S_PARSE = 3'd1,
        S_SYNC  = 3'd2,
        S_DONE  = 3'd3
    } state_t;

    function automatic logic is_digit_char(input logic [7:0] c);
        return (c >= ASCII_0) && (c <= ASCII_9);
    endfunction

    function automatic logic is_term_char(input logic [7:0] c);
        return (c == ASCII_SP) || (c == ASCII_CR) || (c == ASCII_LF);
    endfunction

endpackage

// File: rtl/ascii_dec_rx_if.sv
// RX FIFO read port plus ALU operand handshake; the decoder is the master,
// the FIFO/ALU side (or a testbench) is the slave.
interface ascii_dec_rx_if #(
    parameter int unsigned NBIT = 8
) ();

    logic            fifo_empty;
    logic [7:0]      DATO_FIFO;
    logic            RD_FIFO;
    logic            alu_ready;
    logic            DATO_VALID;
    logic [NBIT-1:0] DATO_A;
    logic [NBIT-1:0] DATO_B;
    logic [NBIT-1:0] DATO_OP;

    modport master (
        input  fifo_empty, DATO_FIFO, alu_ready,
        output RD_FIFO, DATO_VALID, DATO_A, DATO_B, DATO_OP
    );

    modport slave (
        output fifo_empty, DATO_FIFO, alu_ready,
        input  RD_FIFO, DATO_VALID, DATO_A, DATO_B, DATO_OP
    );

endinterface

// File: rtl/ascii_char_class.sv
// Combinational ASCII classifier: decimal digit, field terminator, digit value.
module ascii_char_class
    import ascii_dec_rx_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_digit,
    output logic       is_term,
    output logic [3:0] digit
);

    always_comb begin
        is_digit = is_digit_char(ch);
        is_term  = is_term_char(ch);
        // low nibble of '0'..'9' is the digit value
        digit    = is_digit ? ch[3:0] : 4'd0;
    end

endmodule

// File: rtl/ascii_dec_rx.sv
// ASCII decimal command receiver: three terminated fields -> A/B/OP for the ALU.
// Optional echo to the TX FIFO when ASCII_DEC_RX_ECHO_EN is defined.
module ascii_dec_rx
    import ascii_dec_rx_pkg::*;
#(
    parameter int unsigned NBIT = 8
) (
    input  logic           CLK,
    input  logic           RESET,
    ascii_dec_rx_if.master bus,
    output logic           ERR,
    output logic [2:0]     STATE
`ifdef ASCII_DEC_RX_ECHO_EN
    ,
    input  logic           tx_fifo_full,
    output logic           WR_FIFO_ECHO,
    output logic [7:0]     ECHO_DATA
`endif
);

    localparam int unsigned AW = NBIT + 4;
    localparam logic [AW-1:0] MAXV = {4'b0000, {NBIT{1'b1}}};

    state_t          state, state_n;
    logic [7:0]      ch, ch_n;
    logic [AW-1:0]   acc, acc_n, acc_mul;
    logic            ovf, ovf_n;
    logic [2:0]      ndig, ndig_n;
    logic [1:0]      field, field_n;
    logic            sync_ph, sync_ph_n;
    logic [NBIT-1:0] a_r, a_n, b_r, b_n, op_r, op_n;
    logic            rd, err, parse_go;
    logic            is_digit, is_term;
    logic [3:0]      digit;

    ascii_char_class u_class (
        .ch       (ch),
        .is_digit (is_digit),
        .is_term  (is_term),
        .digit    (digit)
    );

    // acc*10 + digit; cannot wrap while ovf is clear since acc <= 2**NBIT-1
    assign acc_mul = (acc << 3) + (acc << 1) + {{NBIT{1'b0}}, digit};

`ifdef ASCII_DEC_RX_ECHO_EN
    assign parse_go     = !tx_fifo_full;
    assign WR_FIFO_ECHO = (state == S_PARSE) && !tx_fifo_full;
    assign ECHO_DATA    = ch;
`else
    assign parse_go = 1'b1;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= S_READ;
            ch      <= '0;
            acc     <= '0;
            ovf     <= 1'b0;
            ndig    <= '0;
            field   <= '0;
            sync_ph <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            op_r    <= '0;
        end else begin
            state   <= state_n;
            ch      <= ch_n;
            acc     <= acc_n;
            ovf     <= ovf_n;
            ndig    <= ndig_n;
            field   <= field_n;
            sync_ph <= sync_ph_n;
            a_r     <= a_n;
            b_r     <= b_n;
            op_r    <= op_n;
        end
    end

    always_comb begin
        state_n   = state;
        ch_n      = ch;
        acc_n     = acc;
        ovf_n     = ovf;
        ndig_n    = ndig;
        field_n   = field;
        sync_ph_n = sync_ph;
        a_n       = a_r;
        b_n       = b_r;
        op_n      = op_r;
        rd        = 1'b0;
        err       = 1'b0;

        case (state)
            S_READ: begin
                if (!bus.fifo_empty) begin
                    rd      = 1'b1;
                    ch_n    = bus.DATO_FIFO;
                    state_n = S_PARSE;
                end
            end

            S_PARSE: begin
                if (parse_go) begin
                    if (is_digit) begin
                        acc_n   = acc_mul;
                        ovf_n   = ovf | (acc_mul > MAXV);
                        ndig_n  = (ndig == NDIG_MAX) ? ndig : ndig + 3'd1;
                        state_n = S_READ;
                    end else if (is_term) begin
                        state_n = S_READ;
                        if (ndig == 3'd0) begin
                            // repeated separator: nothing to commit
                        end else if (ovf) begin
                            err     = 1'b1;
                            acc_n   = '0;
                            ovf_n   = 1'b0;
                            ndig_n  = '0;
                            field_n = '0;
                        end else begin
                            if (field == 2'd0)      a_n  = acc[NBIT-1:0];
                            else if (field == 2'd1) b_n  = acc[NBIT-1:0];
                            else                    op_n = acc[NBIT-1:0];
                            acc_n  = '0;
                            ndig_n = '0;
                            if (field == 2'd2) begin
                                field_n = '0;
                                state_n = S_DONE;
                            end else begin
                                field_n = field + 2'd1;
                            end
                        end
                    end else begin
                        err       = 1'b1;
                        acc_n     = '0;
                        ovf_n     = 1'b0;
                        ndig_n    = '0;
                        field_n   = '0;
                        sync_ph_n = 1'b0;
                        state_n   = S_SYNC;
                    end
                end
            end

            // sync_ph alternates pop / inspect to keep the 2-cycle byte rhythm
            S_SYNC: begin
                if (!sync_ph) begin
                    if (!bus.fifo_empty) begin
                        rd        = 1'b1;
                        ch_n      = bus.DATO_FIFO;
                        sync_ph_n = 1'b1;
                    end
                end else begin
                    sync_ph_n = 1'b0;
                    if (is_term) state_n = S_READ;
                end
            end

            S_DONE: begin
                if (bus.alu_ready) state_n = S_READ;
            end

            default: state_n = S_READ;
        endcase
    end

    // reset leaves state at S_READ, so the pop strobe is also held off by RESET
    assign bus.RD_FIFO    = rd & RESET;
    assign bus.DATO_VALID = (state == S_DONE);
    assign bus.DATO_A     = a_r;
    assign bus.DATO_B     = b_r;
    assign bus.DATO_OP    = op_r;
    assign ERR            = err;
    assign STATE          = state;

endmodule

// File: tb/tb_ascii_dec_rx.sv
// Directed self-checking bench for ascii_dec_rx with a show-ahead RX FIFO model.
module tb_ascii_dec_rx;
    import ascii_dec_rx_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       ERR;
    logic [2:0] STATE;
`ifdef ASCII_DEC_RX_ECHO_EN
    logic       tx_fifo_full = 1'b0;
    logic       wr_echo;
    logic [7:0] echo_data;
`endif

    ascii_dec_rx_if #(.NBIT(8)) bus ();

    ascii_dec_rx #(.NBIT(8)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus),
        .ERR   (ERR),
        .STATE (STATE)
`ifdef ASCII_DEC_RX_ECHO_EN
        ,
        .tx_fifo_full (tx_fifo_full),
        .WR_FIFO_ECHO (wr_echo),
        .ECHO_DATA    (echo_data)
`endif
    );

    always #5 CLK = ~CLK;

    logic [7:0] q[$];
    bit         toggle_en = 1'b0;
    int         rd_cnt = 0, err_cnt = 0, valid_cnt = 0, empty_pops = 0;
    int         rd_b, err_b, valid_b, empty_b;
    int         vectors = 0, miscompares = 0;

    // FIFO model and event counters: observe mid-cycle, update just after the edge
    initial begin
        bit rd_now, empty_now, phase;
        phase          = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.DATO_FIFO  = 8'hFF;
        forever begin
            @(negedge CLK);
            rd_now    = bus.RD_FIFO;
            empty_now = bus.fifo_empty;
            if (rd_now) rd_cnt++;
            if (rd_now && empty_now) empty_pops++;
            if (ERR) err_cnt++;
            if (bus.DATO_VALID) valid_cnt++;
            @(posedge CLK);
            #1;
            if (rd_now && !empty_now && q.size() > 0) void'(q.pop_front());
            phase          = ~phase;
            bus.fifo_empty = (q.size() == 0) || (toggle_en && phase);
            bus.DATO_FIFO  = bus.fifo_empty ? 8'hFF : q[0];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endtask

    task automatic at_edge();
        @(posedge CLK);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic mark();
        rd_b    = rd_cnt;
        err_b   = err_cnt;
        valid_b = valid_cnt;
        empty_b = empty_pops;
    endtask

    task automatic do_reset();
        at_edge();
        RESET = 1'b0;
        q.delete();
        toggle_en = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        RESET = 1'b1;
        mark();
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge CLK);
            seen = bus.DATO_VALID;
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        RESET         = 1'b0;
        bus.alu_ready = 1'b0;
        push_str("5");

        // reset state, with a byte waiting in the FIFO
        idle(3);
        chk("rst_state", {29'd0, STATE}, {29'd0, S_READ});
        chk("rst_rd", {31'd0, bus.RD_FIFO}, 32'd0);
        chk("rst_valid", {31'd0, bus.DATO_VALID}, 32'd0);
        chk("rst_err", {31'd0, ERR}, 32'd0);
        chk("rst_a", {24'd0, bus.DATO_A}, 32'd0);
        chk("rst_b", {24'd0, bus.DATO_B}, 32'd0);
        chk("rst_op", {24'd0, bus.DATO_OP}, 32'd0);
        at_edge();
        RESET = 1'b1;

        // 1: basic command, ALU ready throughout
        do_reset();
        bus.alu_ready = 1'b1;
        push_str("12 34 5\015");
        wait_valid("t1_valid", 60);
        chk("t1_a", {24'd0, bus.DATO_A}, 32'd12);
        chk("t1_b", {24'd0, bus.DATO_B}, 32'd34);
        chk("t1_op", {24'd0, bus.DATO_OP}, 32'd5);
        idle(10);
        chk("t1_valid_cycles", valid_cnt - valid_b, 32'd1);
        chk("t1_pops", rd_cnt - rd_b, 32'd8);
        chk("t1_err", err_cnt - err_b, 32'd0);

        // 2: max value, zero, repeated separators, ALU stalls 10 cycles
        do_reset();
        bus.alu_ready = 1'b0;
        push_str("255  0\015\015\012");
        push_str("7 ");
        wait_valid("t2_valid", 80);
        push_str("9 ");
        idle(9);
        chk("t2_valid_held", {31'd0, bus.DATO_VALID}, 32'd1);
        chk("t2_a", {24'd0, bus.DATO_A}, 32'd255);
        chk("t2_b", {24'd0, bus.DATO_B}, 32'd0);
        chk("t2_op", {24'd0, bus.DATO_OP}, 32'd7);
        chk("t2_no_pop_in_hold", rd_cnt - rd_b, 32'd11);
        at_edge();
        bus.alu_ready = 1'b1;
        idle(12);
        chk("t2_valid_cycles", valid_cnt - valid_b, 32'd11);
        chk("t2_pops_after", rd_cnt - rd_b, 32'd13);
        chk("t2_next_a", {24'd0, bus.DATO_A}, 32'd9);
        chk("t2_err", err_cnt - err_b, 32'd0);

        // 3: overflow by value restarts the command
        do_reset();
        bus.alu_ready = 1'b1;
        push_str("256 1 2\015");
        idle(30);
        chk("t3_err", err_cnt - err_b, 32'd1);
        chk("t3_no_valid", valid_cnt - valid_b, 32'd0);
        chk("t3_a", {24'd0, bus.DATO_A}, 32'd1);
        chk("t3_b", {24'd0, bus.DATO_B}, 32'd2);
        chk("t3_op", {24'd0, bus.DATO_OP}, 32'd0);
        chk("t3_pops", rd_cnt - rd_b, 32'd8);

        // 4: bad character, resync at next separator
        do_reset();
        push_str("1x3 4 5 6 7\015");
        wait_valid("t4_valid", 80);
        chk("t4_a", {24'd0, bus.DATO_A}, 32'd4);
        chk("t4_b", {24'd0, bus.DATO_B}, 32'd5);
        chk("t4_op", {24'd0, bus.DATO_OP}, 32'd6);
        idle(20);
        chk("t4_err", err_cnt - err_b, 32'd1);
        chk("t4_valid_cycles", valid_cnt - valid_b, 32'd1);
        chk("t4_pops", rd_cnt - rd_b, 32'd12);
        chk("t4_next_a", {24'd0, bus.DATO_A}, 32'd7);
        chk("t4_state", {29'd0, STATE}, {29'd0, S_READ});

        // 5: FIFO empty flag toggling every cycle
        do_reset();
        toggle_en = 1'b1;
        push_str("9 8 7\015");
        wait_valid("t5_valid", 100);
        chk("t5_a", {24'd0, bus.DATO_A}, 32'd9);
        chk("t5_b", {24'd0, bus.DATO_B}, 32'd8);
        chk("t5_op", {24'd0, bus.DATO_OP}, 32'd7);
        idle(10);
        chk("t5_pop_while_empty", empty_pops - empty_b, 32'd0);
        chk("t5_pops", rd_cnt - rd_b, 32'd6);
        chk("t5_err", err_cnt - err_b, 32'd0);
        toggle_en = 1'b0;

        // 6: reset in the middle of a field, then a fresh command
        push_str("12");
        idle(6);
        at_edge();
        RESET = 1'b0;
        push_str("3 4 5\015");
        idle(2);
        chk("t6_state", {29'd0, STATE}, {29'd0, S_READ});
        chk("t6_rd", {31'd0, bus.RD_FIFO}, 32'd0);
        chk("t6_valid", {31'd0, bus.DATO_VALID}, 32'd0);
        chk("t6_a_cleared", {24'd0, bus.DATO_A}, 32'd0);
        chk("t6_op_cleared", {24'd0, bus.DATO_OP}, 32'd0);
        at_edge();
        RESET = 1'b1;
        mark();
        wait_valid("t6_valid_seen", 60);
        chk("t6_a", {24'd0, bus.DATO_A}, 32'd3);
        chk("t6_b", {24'd0, bus.DATO_B}, 32'd4);
        chk("t6_op", {24'd0, bus.DATO_OP}, 32'd5);
        idle(5);
        chk("t6_err", err_cnt - err_b, 32'd0);
        chk("t6_pops", rd_cnt - rd_b, 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
